// File: rtl/am_audio_conditioner.sv
// AM audio conditioner: boxcar decimation of the envelope magnitude, leaky-integrator
// DC removal, saturated signed audio output and a first-order sigma-delta pin DAC stream.
module am_audio_conditioner #(
    parameter int DECIM_LOG2 = 6,
    parameter int DC_SHIFT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] d_in,
    output logic [11:0] audio_out,
    output logic        audio_valid,
    output logic        pwm_out
);

    localparam int AW = 12 + DECIM_LOG2;
    localparam int QW = 12 + DC_SHIFT;

    logic [DECIM_LOG2-1:0] cnt;
    logic [AW-1:0]         acc;
    logic [AW-1:0]         acc_sum;
    logic [11:0]           avg_r;
    logic                  stb_r;
    logic [QW-1:0]         dc_q;
    logic [QW-1:0]         dc_q_nxt;
    logic [11:0]           dc;
    logic signed [12:0]    diff;
    logic [11:0]           clamped;
    logic [11:0]           sd_acc;
    logic [11:0]           ob;
    logic [12:0]           sd_sum;

    assign acc_sum = acc + AW'(d_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            acc   <= '0;
            avg_r <= '0;
            stb_r <= 1'b0;
        end else begin
            cnt <= cnt + DECIM_LOG2'(1);
            if (&cnt) begin
                avg_r <= 12'(acc_sum >> DECIM_LOG2);
                acc   <= '0;
                stb_r <= 1'b1;
            end else begin
                acc   <= acc_sum;
                stb_r <= 1'b0;
            end
        end
    end

    // dc_q holds the tracked level scaled by 2^DC_SHIFT; floor truncation keeps it limit-cycle free.
    assign dc       = 12'(dc_q >> DC_SHIFT);
    assign diff     = $signed({1'b0, avg_r}) - $signed({1'b0, dc});
    assign dc_q_nxt = dc_q + QW'(avg_r) - QW'(dc);

    always_comb begin
        clamped = diff[11:0];
        if (diff > 13'sd2047)
            clamped = 12'h7FF;
        else if (diff < -13'sd2048)
            clamped = 12'h800;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc_q        <= '0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
        end else if (stb_r) begin
            dc_q        <= dc_q_nxt;
            audio_out   <= clamped;
            audio_valid <= 1'b1;
        end else begin
            audio_valid <= 1'b0;
        end
    end

    // Offset-binary view of the audio sample; the accumulator carry is the DAC bit.
    assign ob     = {~audio_out[11], audio_out[10:0]};
    assign sd_sum = {1'b0, sd_acc} + {1'b0, ob};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_acc  <= '0;
            pwm_out <= 1'b0;
        end else begin
            sd_acc  <= sd_sum[11:0];
            pwm_out <= sd_sum[12];
        end
    end

endmodule

// File: tb/tb_am_audio_conditioner.sv
// Directed self-checking bench for am_audio_conditioner: default build plus two small
// parameter builds so the slow DC-tracker settling cases fit in a short run.
module tb_am_audio_conditioner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] d_a = '0, d_b = '0, d_c = '0;
    logic [11:0] audio_a, audio_b, audio_c;
    logic        valid_a, valid_b, valid_c;
    logic        pwm_a, pwm_b, pwm_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    am_audio_conditioner dut_a (
        .clk(clk), .rst(rst), .d_in(d_a),
        .audio_out(audio_a), .audio_valid(valid_a), .pwm_out(pwm_a)
    );

    am_audio_conditioner #(.DECIM_LOG2(1), .DC_SHIFT(1)) dut_b (
        .clk(clk), .rst(rst), .d_in(d_b),
        .audio_out(audio_b), .audio_valid(valid_b), .pwm_out(pwm_b)
    );

    am_audio_conditioner #(.DECIM_LOG2(1), .DC_SHIFT(8)) dut_c (
        .clk(clk), .rst(rst), .d_in(d_c),
        .audio_out(audio_c), .audio_valid(valid_c), .pwm_out(pwm_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int vcnt;
        int ones;
        int stuck;
        int nz;
        logic prev;
        logic [3:0] pat;
        int exp_b[10];

        exp_b = '{100, 50, 25, 13, 6, 3, 2, 1, 0, 0};

        #1 rst = 1'b1;
        #1;
        chk("rst_audio_a", int'($signed(audio_a)), 0);
        chk("rst_valid_a", int'(valid_a), 0);
        chk("rst_pwm_a", int'(pwm_a), 0);
        chk("rst_audio_b", int'($signed(audio_b)), 0);
        chk("rst_pwm_c", int'(pwm_c), 0);

        // Constant 1000: first output 1000 at edge 65, second 997 at edge 129.
        d_a = 12'd1000;
        do_reset();
        vcnt = 0;
        pat = '0;
        for (int e = 1; e <= 64; e++) begin
            tick();
            if (e <= 4) pat = {pat[2:0], pwm_a};
            vcnt += int'(valid_a);
        end
        chk("pwm_after_reset_0101", int'(pat), 5);
        chk("no_valid_before_65", vcnt, 0);
        tick();
        chk("valid_edge65", int'(valid_a), 1);
        chk("audio_first_1000", int'($signed(audio_a)), 1000);
        vcnt = 0;
        for (int e = 66; e <= 128; e++) begin
            tick();
            vcnt += int'(valid_a);
        end
        chk("no_valid_66_128", vcnt, 0);
        tick();
        chk("valid_edge129", int'(valid_a), 1);
        chk("audio_second_997", int'($signed(audio_a)), 997);
        tick();
        chk("valid_drop_130", int'(valid_a), 0);

        // audio_out = 1024 held for 64 edges: ob = 3072 gives exactly 48 ones in 64.
        d_a = 12'd1024;
        do_reset();
        repeat (65) tick();
        chk("audio_1024", int'($signed(audio_a)), 1024);
        ones = 0;
        for (int e = 66; e <= 129; e++) begin
            tick();
            ones += int'(pwm_a);
        end
        chk("pwm_ones_ob3072", ones, 48);
        chk("audio_1020", int'($signed(audio_a)), 1020);

        // Alternating 0/4095 every clock.
        d_a = 12'd0;
        do_reset();
        for (int e = 1; e <= 64; e++) begin
            tick();
            d_a = (e % 2 == 1) ? 12'd4095 : 12'd0;
        end
        tick();
        chk("alt_first_2047", int'($signed(audio_a)), 2047);

        // Positive saturation, then asynchronous reset mid-window at cnt=30.
        d_a = 12'd4095;
        do_reset();
        repeat (65) tick();
        chk("possat_first", int'($signed(audio_a)), 2047);
        repeat (64) tick();
        chk("possat_valid2", int'(valid_a), 1);
        chk("possat_second", int'($signed(audio_a)), 2047);
        repeat (29) tick();
        #3 rst = 1'b1;
        #1;
        chk("async_rst_audio", int'($signed(audio_a)), 0);
        chk("async_rst_pwm", int'(pwm_a), 0);
        repeat (3) tick();
        chk("held_rst_audio", int'($signed(audio_a)), 0);
        chk("held_rst_valid", int'(valid_a), 0);
        chk("held_rst_pwm", int'(pwm_a), 0);
        d_a = 12'd500;
        rst = 1'b0;
        vcnt = 0;
        for (int e = 1; e <= 64; e++) begin
            tick();
            vcnt += int'(valid_a);
        end
        chk("postrst_no_early_valid", vcnt, 0);
        tick();
        chk("postrst_valid65", int'(valid_a), 1);
        chk("postrst_audio_500", int'($signed(audio_a)), 500);

        // DECIM_LOG2=1, DC_SHIFT=1, d_in=100: outputs 100,50,25,13,6,3,2,1,0,0.
        d_b = 12'd100;
        do_reset();
        for (int e = 1; e <= 21; e++) begin
            tick();
            if (e >= 3 && (e % 2 == 1)) begin
                chk($sformatf("sweep_valid_e%0d", e), int'(valid_b), 1);
                chk($sformatf("sweep_audio_e%0d", e), int'($signed(audio_b)), exp_b[(e - 3) / 2]);
            end else begin
                chk($sformatf("sweep_novalid_e%0d", e), int'(valid_b), 0);
            end
        end

        // Settle at 1000, then audio 0: pwm toggles every clock, 2048 ones per 4096.
        d_c = 12'd1000;
        do_reset();
        repeat (8001) tick();
        chk("settle_valid", int'(valid_c), 1);
        chk("settle_audio_0", int'($signed(audio_c)), 0);
        ones = 0;
        stuck = 0;
        nz = 0;
        prev = pwm_c;
        for (int i = 0; i < 4096; i++) begin
            tick();
            ones += int'(pwm_c);
            if (pwm_c == prev) stuck++;
            prev = pwm_c;
            if (valid_c && audio_c != 12'd0) nz++;
        end
        chk("settled_pwm_ones", ones, 2048);
        chk("settled_pwm_non_toggle", stuck, 0);
        chk("settled_audio_nonzero", nz, 0);

        // Settle at 4000, step to 0 on a window boundary: -2048 and a silent DAC.
        d_c = 12'd4000;
        do_reset();
        repeat (8000) tick();
        chk("pre_step_audio_0", int'($signed(audio_c)), 0);
        d_c = 12'd0;
        tick();
        chk("pre_step_last_0", int'($signed(audio_c)), 0);
        tick();
        tick();
        chk("negsat_valid", int'(valid_c), 1);
        chk("negsat_first", int'($signed(audio_c)), -2048);
        ones = 0;
        for (int e = 8004; e <= 8099; e++) begin
            tick();
            ones += int'(pwm_c);
        end
        chk("negsat_pwm_ones", ones, 0);
        chk("negsat_still", int'($signed(audio_c)), -2048);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
